mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Sits between the pipelined CPU and the memory. It replaces the separate instruction and data ports with a sequenced request/acknowledge transaction.
- Data accesses win by default. A starvation guard and a no-acknowledge watchdog keep forward progress.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding,
// default widths and memory access-size encodings.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_WORD_W = 32;
  localparam int DEFAULT_MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_WORD = 2'd2;

  function automatic logic isGrant(input arbState_t s);
    return (s == GNT_I) || (s == GNT_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Loadable down-counter with enable and clear; expired is high while enabled
// and the count has run out.
module arb_watchdog #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             enable,
  input  logic             clear,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = enable && (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// data access; data wins by default, with a starvation guard and ack watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W       = DEFAULT_WORD_W,
  parameter int MODE_W       = DEFAULT_MODE_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_ready,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [MODE_W-1:0] d_mode,
  output logic              d_ready,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [MODE_W-1:0] mem_mode,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int STREAK_W = 4;
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arbState_t           state, nextState;
  logic [STREAK_W-1:0] streak, streakNext;
  logic                grantD, grantI, inGrant, complete, wdExpired;
  logic                memReqNext, memWeNext, ifReadyNext, dReadyNext, timeoutNext;
  logic [WORD_W-1:0]   memAddrNext, memWdataNext, ifRdataNext, dRdataNext, compData;
  logic [MODE_W-1:0]   memModeNext;

  // IF is forced through once it has watched STARVE_LIMIT data grants in a row
  assign grantD   = d_req && !(if_req && (streak == STREAK_MAX));
  assign grantI   = if_req && !grantD;
  assign inGrant  = isGrant(state);
  assign complete = inGrant && (mem_ack || wdExpired);

  arb_watchdog #(
    .CNT_W(CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == IDLE) && (grantD || grantI)),
    .loadValue(WD_LOAD),
    .enable   ((TIMEOUT != 0) && inGrant),
    .clear    (state == DONE),
    .expired  (wdExpired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (grantD)      nextState = GNT_D;
        else if (grantI) nextState = GNT_I;
      end
      GNT_I, GNT_D: if (complete) nextState = DONE;
      DONE:         nextState = IDLE;
      default:      nextState = IDLE;
    endcase
  end

  always_comb begin
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    memModeNext  = mem_mode;
    streakNext   = streak;
    ifReadyNext  = 1'b0;
    dReadyNext   = 1'b0;
    timeoutNext  = 1'b0;
    ifRdataNext  = if_rdata;
    dRdataNext   = d_rdata;
    compData     = (mem_ack && !mem_we) ? mem_rdata : '0;
    unique case (state)
      IDLE: begin
        if (grantD) begin
          memReqNext   = 1'b1;
          memWeNext    = d_we;
          memAddrNext  = d_addr;
          memWdataNext = d_wdata;
          memModeNext  = d_mode;
          if (!if_req)                 streakNext = '0;
          else if (streak != STREAK_MAX) streakNext = streak + STREAK_W'(1);
        end else if (grantI) begin
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = if_addr;
          memWdataNext = '0;
          memModeNext  = MODE_W'(MODE_WORD);
          streakNext   = '0;
        end
      end
      GNT_I: begin
        if (complete) begin
          memReqNext  = 1'b0;
          ifReadyNext = 1'b1;
          ifRdataNext = compData;
          timeoutNext = !mem_ack;
        end
      end
      GNT_D: begin
        if (complete) begin
          memReqNext  = 1'b0;
          dReadyNext  = 1'b1;
          dRdataNext  = compData;
          timeoutNext = !mem_ack;
        end
      end
      default: ;
    endcase
  end

  // All outputs are registered; ready/timeout pulses land in the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_mode    <= '0;
      streak      <= '0;
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
      timeout_err <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      mem_req     <= memReqNext;
      mem_we      <= memWeNext;
      mem_addr    <= memAddrNext;
      mem_wdata   <= memWdataNext;
      mem_mode    <= memModeNext;
      streak      <= streakNext;
      if_ready    <= ifReadyNext;
      d_ready     <= dReadyNext;
      timeout_err <= timeoutNext;
      if_rdata    <= ifRdataNext;
      d_rdata     <= dRdataNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference
// model of arbitration, starvation streak, latency and watchdog abort.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int WORD_W       = 32;
  localparam int MODE_W       = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [WORD_W-1:0] if_addr;
  logic              if_ready;
  logic [WORD_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [WORD_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic [MODE_W-1:0] d_mode;
  logic              d_ready;
  logic [WORD_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [MODE_W-1:0] mem_mode;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              timeout_err;

  mem_port_arbiter #(
    .WORD_W      (WORD_W),
    .MODE_W      (MODE_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_mode     (d_mode),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mode   (mem_mode),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          streak = 0;
  logic [31:0] lastI  = 32'h0;
  logic [31:0] lastD  = 32'h0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Called at the negedge of an idle cycle with at least one request driven.
  task automatic serve(input int ackDelay, input logic [31:0] memData, output bit wonD);
    logic [31:0] expAddr, expWdata, expRd;
    logic        expWe;
    logic [1:0]  expMode;
    bit          timedOut, done;
    wonD = d_req && !(if_req && (streak == STARVE_LIMIT));
    if (wonD) begin
      expAddr  = d_addr;
      expWe    = d_we;
      expWdata = d_wdata;
      expMode  = d_mode;
      streak   = if_req ? ((streak < STARVE_LIMIT) ? streak + 1 : STARVE_LIMIT) : 0;
    end else begin
      expAddr  = if_addr;
      expWe    = 1'b0;
      expWdata = 32'h0;
      expMode  = MODE_WORD;
      streak   = 0;
    end
    timedOut = (ackDelay > TIMEOUT - 1);
    expRd    = (timedOut || expWe) ? 32'h0 : memData;
    tick;
    done = 1'b0;
    for (int k = 0; !done; k++) begin
      checkVal("memReqHeld", 32'(mem_req), 32'd1);
      checkVal("memAddr", mem_addr, expAddr);
      checkVal("memWe", 32'(mem_we), 32'(expWe));
      checkVal("memMode", 32'(mem_mode), 32'(expMode));
      if (wonD) checkVal("memWdata", mem_wdata, expWdata);
      checkVal("readyInGrant", {30'b0, if_ready, d_ready}, 32'd0);
      if (k == ackDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = memData;
      end
      if ($urandom_range(0, 3) == 0) begin
        if (wonD) begin
          d_addr  = $urandom;
          d_wdata = $urandom;
        end else begin
          if_addr = $urandom;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        if (wonD) d_req = 1'b0;
        else      if_req = 1'b0;
      end
      done = (k == ackDelay) || (k == TIMEOUT - 1);
      tick;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    checkVal("memReqDone", 32'(mem_req), 32'd0);
    checkVal("timeoutErr", 32'(timeout_err), 32'(timedOut));
    if (wonD) begin
      lastD = expRd;
      checkVal("dReady", 32'(d_ready), 32'd1);
      checkVal("ifReadyQuiet", 32'(if_ready), 32'd0);
      d_req = 1'b0;
    end else begin
      lastI = expRd;
      checkVal("ifReady", 32'(if_ready), 32'd1);
      checkVal("dReadyQuiet", 32'(d_ready), 32'd0);
      if_req = 1'b0;
    end
    checkVal("dRdata", d_rdata, lastD);
    checkVal("ifRdata", if_rdata, lastI);
    tick;
    checkVal("idleQuiet", {28'b0, timeout_err, mem_req, if_ready, d_ready}, 32'd0);
  endtask

  task automatic raiseD(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] mode);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_mode  = mode;
  endtask

  initial begin
    bit       w;
    bit [5:0] starvePattern;
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_mode    = 2'd0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    repeat (3) tick;
    checkVal("rstCtl", {27'b0, mem_req, mem_we, if_ready, d_ready, timeout_err}, 32'd0);
    checkVal("rstAddr", mem_addr, 32'd0);
    checkVal("rstRdata", if_rdata | d_rdata | mem_wdata, 32'd0);
    reset = 1'b0;
    tick;

    // Reset in the middle of a data grant, with a late ack
    raiseD(1'b0, 32'h10010020, 32'h0, MODE_WORD);
    tick;
    checkVal("preRstReq", 32'(mem_req), 32'd1);
    tick;
    reset = 1'b1;
    d_req = 1'b0;
    tick;
    checkVal("postRstReq", 32'(mem_req), 32'd0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkVal("postRstQuiet", {29'b0, mem_req, if_ready, d_ready}, 32'd0);
      tick;
    end
    streak = 0;

    // Instruction fetch alone
    if_req  = 1'b1;
    if_addr = 32'h00400010;
    serve(1, 32'h8C080004, w);
    checkVal("fetchWinner", 32'(w), 32'd0);
    checkVal("fetchData", if_rdata, 32'h8C080004);

    // Byte store
    raiseD(1'b1, 32'h10010004, 32'hDEADBEEF, MODE_BYTE);
    serve(2, 32'h12345678, w);
    checkVal("storeWinner", 32'(w), 32'd1);
    checkVal("storeRdata", d_rdata, 32'd0);

    // Simultaneous requests: data first, then fetch
    if_req  = 1'b1;
    if_addr = 32'h00400014;
    raiseD(1'b0, 32'h10010000, 32'h0, MODE_WORD);
    serve(1, 32'h00000055, w);
    checkVal("bothFirst", 32'(w), 32'd1);
    serve(3, 32'h24020001, w);
    checkVal("bothSecond", 32'(w), 32'd0);

    // Continuous data loads against a waiting fetch
    starvePattern = 6'b101111;
    if_req  = 1'b1;
    if_addr = 32'h00400018;
    for (int i = 0; i < 6; i++) begin
      if (!d_req) raiseD(1'b0, 32'h10010000 + 32'(i * 4), 32'h0, MODE_WORD);
      if (!if_req) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      serve(int'($urandom_range(1, 3)), $urandom, w);
      checkVal("starveOrder", 32'(w), 32'(starvePattern[i]));
    end
    if (if_req) serve(1, $urandom, w);
    if (d_req) serve(1, $urandom, w);

    // Watchdog abort, then a normal access
    raiseD(1'b0, 32'h10010040, 32'h0, MODE_WORD);
    serve(100, 32'h11111111, w);
    checkVal("timeoutRdata", d_rdata, 32'd0);
    raiseD(1'b0, 32'h10010044, 32'h0, MODE_HALF);
    serve(2, 32'h22222222, w);
    checkVal("afterTimeout", d_rdata, 32'h22222222);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if (!if_req && ($urandom_range(0, 2) != 0)) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (!d_req && ($urandom_range(0, 2) != 0))
        raiseD(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)));
      if (!if_req && !d_req) begin
        tick;
        checkVal("idleNoReq", 32'(mem_req), 32'd0);
      end else begin
        serve(int'($urandom_range(1, 10)), $urandom, w);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
